// File: rtl/conv3x3_avs_if.sv
// Avalon-MM bus bundle for the conv3x3 engine: the initiator drives the
// address phase and the responder answers with waitrequest and read data.
interface conv3x3_avs_if;
  logic [4:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/conv3x3_avs.sv
// Memory-mapped 3x3 multiply-accumulate engine: nine s8 weights times nine u8
// pixels, one tap per cycle, 20-bit signed result with done/irq reporting.
module conv3x3_avs (
  input  logic         clk,
  input  logic         reset,
  conv3x3_avs_if.slave avs,
  output logic         irq
);
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int TAPS   = 9;
  localparam logic [ADDR_W-1:0] ADDR_LAST_TAP = 5'h11;
  localparam logic [ADDR_W-1:0] ADDR_CTRL     = 5'h12;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 5'h13;
  localparam logic [ADDR_W-1:0] ADDR_RESULT   = 5'h14;
  localparam logic [ADDR_W-1:0] ADDR_COUNT    = 5'h15;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_FIN} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         idx_reg;
  logic signed [7:0]  kernel_reg [TAPS];
  logic [7:0]         pixel_reg  [TAPS];
  logic signed [19:0] acc_reg;
  logic signed [19:0] result_reg;
  logic [15:0]        count_reg;
  logic               ie_reg, done_reg, busy_reg, irq_reg;
  logic [DATA_W-1:0]  readdata_reg;
  logic               readdatavalid_reg;

  logic               wait_stall, write_ok, ctrl_wr, start_go;
  logic               mac_en, fin_en;
  logic [TAPS-1:0]    kernel_wr, pixel_wr;
  logic signed [16:0] prod;
  logic [3:0]         pix_idx;
  logic [DATA_W-1:0]  read_mux;
  logic               unused_wdata;

  // Only coefficient writes stall; control/status traffic always flows.
  assign wait_stall = avs.write & busy_reg & (avs.address <= ADDR_LAST_TAP);
  assign write_ok   = avs.write & ~wait_stall;
  assign ctrl_wr    = write_ok && (avs.address == ADDR_CTRL);
  assign start_go   = ctrl_wr && avs.writedata[0] && (state_reg == S_IDLE);
  assign unused_wdata = ^avs.writedata[31:8];

  for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap_sel
    assign kernel_wr[gi] = write_ok && (avs.address == ADDR_W'(gi));
    assign pixel_wr[gi]  = write_ok && (avs.address == ADDR_W'(gi + TAPS));
  end

  // Pixel is zero-extended so the signed multiply treats it as unsigned.
  assign prod = 17'(kernel_reg[idx_reg]) * 17'($signed({1'b0, pixel_reg[idx_reg]}));

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_go) state_next = S_MAC;
      S_MAC:   if (idx_reg == 4'd8) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mac_en = (state_reg == S_MAC);
    fin_en = (state_reg == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TAPS; i++) begin
        kernel_reg[i] <= '0;
        pixel_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < TAPS; i++) begin
        if (kernel_wr[i]) kernel_reg[i] <= avs.writedata[7:0];
        if (pixel_wr[i])  pixel_reg[i]  <= avs.writedata[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_reg    <= '0;
      acc_reg    <= '0;
      result_reg <= '0;
      count_reg  <= '0;
      ie_reg     <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      irq_reg    <= 1'b0;
    end else begin
      if (start_go) begin
        acc_reg  <= '0;
        idx_reg  <= '0;
        busy_reg <= 1'b1;
      end else if (mac_en) begin
        acc_reg <= acc_reg + 20'(prod);
        idx_reg <= idx_reg + 4'd1;
      end
      if (fin_en) begin
        result_reg <= acc_reg;
        busy_reg   <= 1'b0;
        count_reg  <= count_reg + 16'd1;
      end
      // Completion outranks a coincident clear; a start always clears.
      if (fin_en)                             done_reg <= 1'b1;
      else if (start_go)                      done_reg <= 1'b0;
      else if (ctrl_wr && avs.writedata[1])   done_reg <= 1'b0;
      if (ctrl_wr) ie_reg <= avs.writedata[2];
      irq_reg <= done_reg & ie_reg;
    end
  end

  assign pix_idx = 4'(avs.address - 5'd9);

  always_comb begin
    read_mux = '0;
    if (avs.address <= 5'd8)
      read_mux = DATA_W'(kernel_reg[avs.address[3:0]]);
    else if (avs.address <= ADDR_LAST_TAP)
      read_mux = {24'b0, pixel_reg[pix_idx]};
    else if (avs.address == ADDR_CTRL)
      read_mux = {29'b0, ie_reg, 2'b0};
    else if (avs.address == ADDR_STATUS)
      read_mux = {30'b0, done_reg, busy_reg};
    else if (avs.address == ADDR_RESULT)
      read_mux = DATA_W'(result_reg);
    else if (avs.address == ADDR_COUNT)
      read_mux = {16'b0, count_reg};
  end

  // A read colliding with a write is dropped entirely.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_reg      <= '0;
      readdatavalid_reg <= 1'b0;
    end else begin
      readdatavalid_reg <= avs.read & ~avs.write;
      if (avs.read & ~avs.write) readdata_reg <= read_mux;
    end
  end

  assign avs.waitrequest   = wait_stall;
  assign avs.readdata      = readdata_reg;
  assign avs.readdatavalid = readdatavalid_reg;
  assign irq               = irq_reg;
endmodule

// File: tb/tb_conv3x3_avs.sv
// Self-checking bench for conv3x3_avs: register table, hand-timed corner
// sequences and randomized convolutions against a plain arithmetic model.
module tb_conv3x3_avs;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq;

  conv3x3_avs_if bus ();
  conv3x3_avs dut (.clk(clk), .reset(reset), .avs(bus.slave), .irq(irq));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int k_m[9];
  int p_m[9];
  int result_m, count_m, pending_m;
  bit ie_m, done_m;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a <= 8)  return 32'(k_m[a]);
    if (a <= 17) return 32'(p_m[a-9]);
    case (a)
      18:      return {29'b0, ie_m, 2'b0};
      19:      return {30'b0, done_m, 1'b0};
      20:      return 32'(result_m);
      21:      return 32'(count_m & 32'hFFFF);
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin k_m[i] = 0; p_m[i] = 0; end
    result_m = 0; count_m = 0; pending_m = 0; ie_m = 0; done_m = 0;
  endtask

  task automatic model_finish();
    done_m = 1; result_m = pending_m; count_m = (count_m + 1) & 32'hFFFF;
  endtask

  // Called at edge+1; returns at edge+1 after the accepting edge.
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d, output int stalls);
    stalls = 0;
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    #1;
    while (bus.waitrequest === 1'b1 && stalls < 100) begin
      @(posedge clk); #1; stalls++;
    end
    if (stalls >= 100) begin
      n_vec++; n_bad++;
      $display("FAIL write_bound: addr %0d still stalled after %0d cycles, want release", a, stalls);
    end
    @(posedge clk); #1;
    bus.write = 1'b0;
    if (a <= 8)                  k_m[a] = $signed(d[7:0]);
    else if (a <= 17)            p_m[a-9] = int'(d[7:0]);
    else if (a == 18) begin
      ie_m = d[2];
      if (d[1]) done_m = 0;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    int s;
    bus_write(a, d, s);
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] data);
    bus.address = a; bus.read = 1'b1;
    @(posedge clk); #1;
    bus.read = 1'b0;
    check($sformatf("rvalid@%0d", a), {31'b0, bus.readdatavalid}, 32'h1);
    data = bus.readdata;
  endtask

  task automatic rd_check(input string name, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check(name, v, exp);
  endtask

  task automatic do_start(input logic [31:0] ctrl);
    pending_m = 0;
    for (int i = 0; i < 9; i++) pending_m += k_m[i] * p_m[i];
    wr(5'd18, ctrl);
    done_m = 0;
  endtask

  // Back-to-back STATUS polls until done; bounded.
  task automatic wait_done(output logic [31:0] first, output int busy_n);
    logic [31:0] v;
    bit seen;
    busy_n = 0; seen = 0; first = 'x;
    bus.address = 5'd19; bus.read = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      v = bus.readdata;
      if (i == 0) first = v;
      if (v[1]) begin seen = 1; break; end
      if (v[0]) busy_n++;
    end
    bus.read = 1'b0;
    if (!seen) begin
      n_vec++; n_bad++;
      $display("FAIL done_bound: status 0x%08h after 40 polls, want done=1", v);
    end
    model_finish();
  endtask

  initial begin
    logic [31:0] v, first;
    int busy_n, stalls, vcount;
    int lap[9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};

    tbl[0]  = '{5'd0,  32'h0000_0080, 32'hFFFF_FF80};
    tbl[1]  = '{5'd4,  32'h0000_017F, 32'h0000_007F};
    tbl[2]  = '{5'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl[3]  = '{5'd9,  32'h0000_00FF, 32'h0000_00FF};
    tbl[4]  = '{5'd17, 32'h00AB_CD12, 32'h0000_0012};
    tbl[5]  = '{5'd18, 32'h0000_0004, 32'h0000_0004};
    tbl[6]  = '{5'd18, 32'h0000_0006, 32'h0000_0004};
    tbl[7]  = '{5'd18, 32'h0000_0000, 32'h0000_0000};
    tbl[8]  = '{5'd19, 32'hFFFF_FFFE, 32'h0000_0000};
    tbl[9]  = '{5'd20, 32'h0000_1234, 32'h0000_0000};
    tbl[10] = '{5'd21, 32'h0000_FFFF, 32'h0000_0000};
    tbl[11] = '{5'd30, 32'h0000_00FF, 32'h0000_0000};

    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and full address sweep
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_rvalid", {31'b0, bus.readdatavalid}, 32'h0);
    check("rst_waitreq", {31'b0, bus.waitrequest}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    vcount = 0;
    bus.read = 1'b1;
    for (int a = 0; a < 32; a++) begin
      bus.address = 5'(a);
      @(posedge clk); #1;
      if (bus.readdatavalid === 1'b1) vcount++;
      check($sformatf("sweep@%0d", a), bus.readdata, 32'h0);
    end
    bus.read = 1'b0;
    @(posedge clk); #1;
    if (bus.readdatavalid === 1'b1) vcount++;
    check("sweep_valid_count", 32'(vcount), 32'd32);

    // Simultaneous read+write: read dropped
    bus.address = 5'd20; bus.read = 1'b1; bus.write = 1'b1; bus.writedata = '0;
    @(posedge clk); #1;
    bus.read = 1'b0; bus.write = 1'b0;
    check("rw_collide_valid", {31'b0, bus.readdatavalid}, 32'h0);

    // Register table
    foreach (tbl[i]) begin
      wr(tbl[i].addr, tbl[i].wdata);
      rd_check($sformatf("tbl[%0d]@%0d", i, tbl[i].addr), tbl[i].addr, tbl[i].exp);
    end

    // Sequence A: ones x 1..9
    for (int i = 0; i < 9; i++) begin wr(5'(i), 32'd1); wr(5'(i + 9), 32'(i + 1)); end
    do_start(32'h1);
    wait_done(first, busy_n);
    check("A_busy_cycles", 32'(busy_n), 32'd10);
    check("A_first_status", first, 32'h1);
    rd_check("A_status", 5'd19, 32'h2);
    rd_check("A_result", 5'd20, 32'd45);
    rd_check("A_count", 5'd21, 32'd1);

    // Sequence B: extremes, start+clear together
    for (int i = 0; i < 9; i++) begin wr(5'(i), 32'h80); wr(5'(i + 9), 32'd255); end
    do_start(32'h3);
    wait_done(first, busy_n);
    check("B_first_status", first, 32'h1);
    rd_check("B_result_min", 5'd20, 32'hFFFB_8480);
    for (int i = 0; i < 9; i++) wr(5'(i), 32'd127);
    do_start(32'h1);
    wait_done(first, busy_n);
    rd_check("B_result_max", 5'd20, 32'h0004_7289);
    rd_check("B_count", 5'd21, 32'd3);

    // Sequence C: Laplacian with interrupt
    for (int i = 0; i < 9; i++) begin wr(5'(i), 32'(lap[i])); wr(5'(i + 9), 32'd100); end
    do_start(32'h5);
    wait_done(first, busy_n);
    check("C_irq_high", {31'b0, irq}, 32'h1);
    rd_check("C_result", 5'd20, 32'h0);
    wr(5'd18, 32'h6);
    check("C_irq_lag", {31'b0, irq}, 32'h1);
    @(posedge clk); #1;
    check("C_irq_low", {31'b0, irq}, 32'h0);
    rd_check("C_status", 5'd19, 32'h0);

    // Sequence D: traffic during MAC
    wr(5'd0, 32'd3);
    do_start(32'h1);
    rd_check("D_old_result", 5'd20, 32'h0);
    bus_write(5'd18, 32'h1, stalls);
    check("D_ctrl_nostall", 32'(stalls), 32'd0);
    bus_write(5'd9, 32'd50, stalls);
    check("D_pixel_stall", 32'(stalls), 32'd8);
    model_finish();
    rd_check("D_result", 5'd20, model_read(20));
    rd_check("D_count", 5'd21, model_read(21));
    rd_check("D_status", 5'd19, model_read(19));
    rd_check("D_pixel0", 5'd9, 32'd50);

    // Sequence E: clear-done coincident with FIN
    do_start(32'h1);
    repeat (9) begin @(posedge clk); #1; end
    wr(5'd18, 32'h2);
    model_finish();
    rd_check("E_fin_wins", 5'd19, model_read(19));
    rd_check("E_result", 5'd20, model_read(20));

    // Sequence F: reset at idx=4
    do_start(32'h1);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    rd_check("F_status", 5'd19, 32'h0);
    rd_check("F_result", 5'd20, 32'h0);
    rd_check("F_count", 5'd21, 32'h0);
    rd_check("F_kernel4", 5'd4, 32'h0);

    // Randomized convolutions
    for (int it = 0; it < 25; it++) begin
      logic [31:0] ctrl;
      int ra;
      for (int i = 0; i < 18; i++)
        if (it == 0 || $urandom_range(1, 0) == 1) wr(5'(i), $urandom);
      ctrl = {29'b0, 1'($urandom), 1'($urandom), 1'b1};
      do_start(ctrl);
      wait_done(first, busy_n);
      check($sformatf("R%0d_busy", it), 32'(busy_n), 32'd10);
      rd_check($sformatf("R%0d_result", it), 5'd20, model_read(20));
      rd_check($sformatf("R%0d_count", it), 5'd21, model_read(21));
      check($sformatf("R%0d_irq", it), {31'b0, irq}, {31'b0, ie_m});
      ra = $urandom_range(31, 0);
      rd_check($sformatf("R%0d_rd@%0d", it, ra), 5'(ra), model_read(ra));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit, want completion");
    $fatal(1, "timeout");
  end
endmodule
